// File: rtl/sync_bus_edge_det.sv
// sync_bus_edge_det
//   Multi-channel synchronizer for asynchronous control inputs (status
//   strobes, external enables, lock indicators) crossing into the clk
//   domain. Each channel passes through a STAGES-deep flop chain, then
//   feeds a registered rise/fall edge detector and a saturating 16-bit
//   edge event counter.
//
//   Optional deglitch filter: define SYNC_BUS_DEGLITCH_EN. Each channel then
//   needs FILT_LEN consecutive cycles of a new synchronized value before
//   sync_out follows it. Without the macro, sync_out is the raw chain output
//   and FILT_LEN is ignored.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   async_in    [CH]  asynchronous channel inputs
//   cnt_clr     synchronous clear of edge_cnt (wins over same-cycle edges)
//   sync_out    [CH]  synchronized (optionally filtered) levels
//   rise_pulse  [CH]  one-cycle pulse per 0->1 of sync_out
//   fall_pulse  [CH]  one-cycle pulse per 1->0 of sync_out
//   any_edge    OR of all rise/fall pulse bits, registered with them
//   edge_cnt    [16]  saturating count of all edge pulses

module sync_bus_edge_det #(
  parameter int              CH       = 4,
  parameter int              STAGES   = 2,
  parameter logic [CH-1:0]   RST_VAL  = {CH{1'b0}},
  parameter int              FILT_LEN = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] async_in,
  input  logic          cnt_clr,
  output logic [CH-1:0] sync_out,
  output logic [CH-1:0] rise_pulse,
  output logic [CH-1:0] fall_pulse,
  output logic          any_edge,
  output logic [15:0]   edge_cnt
);

  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("sync_bus_edge_det: CH out of range 1..32");
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_bus_edge_det: STAGES out of range 2..4");
  end
  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt
    $error("sync_bus_edge_det: FILT_LEN out of range 2..15");
  end

  // synchronizer chain
  logic [CH-1:0] chain [STAGES];
  logic [CH-1:0] raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) chain[k] <= RST_VAL;
    end else begin
      chain[0] <= async_in;
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  assign raw = chain[STAGES-1];

`ifdef SYNC_BUS_DEGLITCH_EN
  // fcnt counts cycles the raw value has disagreed with sync_out; the
  // update happens on the FILT_LEN-th such cycle, so a shorter excursion
  // never reaches sync_out.
  localparam logic [3:0] FILT_TC = 4'(FILT_LEN - 1);

  logic [3:0]    fcnt [CH];
  logic [CH-1:0] filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= RST_VAL;
      for (int i = 0; i < CH; i++) fcnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (raw[i] != filt_q[i]) begin
          if (fcnt[i] == FILT_TC) begin
            filt_q[i] <= raw[i];
            fcnt[i]   <= 4'd0;
          end else begin
            fcnt[i]   <= fcnt[i] + 4'd1;
          end
        end else begin
          fcnt[i] <= 4'd0;
        end
      end
    end
  end

  assign sync_out = filt_q;
`else
  assign sync_out = raw;
`endif

  // edge detect; prev resets to RST_VAL so reset release never pulses
  logic [CH-1:0] prev;
  logic [CH-1:0] rise_nxt;
  logic [CH-1:0] fall_nxt;

  assign rise_nxt = sync_out & ~prev;
  assign fall_nxt = ~sync_out & prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= RST_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_edge   <= 1'b0;
    end else begin
      prev       <= sync_out;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      any_edge   <= |(rise_nxt | fall_nxt);
    end
  end

  // saturating edge counter, counts the registered pulses
  logic [CH-1:0] edges;
  logic [5:0]    n_edges;
  logic [16:0]   cnt_sum;

  assign edges = rise_pulse | fall_pulse;

  always_comb begin
    n_edges = 6'd0;
    for (int i = 0; i < CH; i++) n_edges = n_edges + 6'(edges[i]);
  end

  assign cnt_sum = {1'b0, edge_cnt} + 17'(n_edges);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 16'd0;
    end else if (cnt_clr) begin
      edge_cnt <= 16'd0;
    end else if (cnt_sum[16]) begin
      edge_cnt <= 16'hFFFF;
    end else begin
      edge_cnt <= cnt_sum[15:0];
    end
  end

endmodule

// File: doc/sync_bus_edge_det.md
# sync_bus_edge_det

Parametrised multi-channel synchronizer for asynchronous control inputs (status strobes, external enables, lock indicators) entering the clk domain of the 64QAM upsampling/filter datapath. Each channel runs through a configurable-depth flip-flop chain. The block then produces single-cycle rise and fall pulses and keeps a saturating edge event counter. An optional compile-time deglitch filter is also provided.

## Interface
Parameters:
- CH, 4: number of independent 1-bit channels (1..32)
- STAGES, 2: synchronizer flop depth per channel (2..4)
- RST_VAL, {CH{1'b0}}: per-channel reset value of the synchronizer chain and sync_out
- FILT_LEN, 3: consecutive stable cycles required before sync_out changes (2..15; used only with the deglitch filter compiled in)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- async_in  in  CH  asynchronous channel inputs
- cnt_clr  in  1  synchronous clear of edge_cnt
- sync_out  out  CH  synchronized (optionally filtered) channel levels
- rise_pulse  out  CH  one-cycle pulse per 0→1 transition of sync_out
- fall_pulse  out  CH  one-cycle pulse per 1→0 transition of sync_out
- any_edge  out  1  OR of all rise_pulse and fall_pulse bits
- edge_cnt  out  16  saturating count of all edge pulses

## Operation
- Reset values:
  - All chain stages, sync_out and the internal previous-value register: RST_VAL.
  - rise_pulse, fall_pulse, any_edge, edge_cnt and filter counters: 0.
  - No pulse is generated on reset release, even if async_in differs from RST_VAL. That difference appears later as a normal edge.
- Chain: stage[0] samples async_in each clk edge. stage[k] samples stage[k-1]. The raw synchronized value is r = stage[STAGES-1].
- Without the filter, sync_out = r, with no extra register.
- Edge detect: prev <= sync_out each cycle. rise_pulse <= sync_out & ~prev and fall_pulse <= ~sync_out & prev, both registered. any_edge is registered alongside them.
- edge_cnt increments each cycle by popcount(rise_pulse | fall_pulse), range 0..CH. It saturates at 0xFFFF and never wraps.
  - cnt_clr has priority: it loads 0, and edges pulsed in that same cycle are discarded.
- Channels are independent. Multi-bit values carried on async_in are not guaranteed coherent across channels; that is the user's responsibility.

## Timing
- async_in changes and meets setup before edge 1: r changes at edge STAGES.
- Without the filter:
  - sync_out changes at edge STAGES.
  - The pulse is high for exactly the cycle after edge STAGES+1.
  - edge_cnt reflects the pulse at edge STAGES+2.
- Pulse width is always exactly 1 cycle. Back-to-back toggles of sync_out on consecutive cycles give alternating rise and fall pulses on consecutive cycles.
- Input high for less than one clk period may be missed or captured; either is legal. Once captured, it yields exactly one rise and one fall pulse.

## Configuration
- Macro SYNC_BUS_DEGLITCH_EN.
- Defined: each channel gets a 4-bit stability counter fcnt.
  - Each cycle r ≠ sync_out: fcnt increments.
  - When r ≠ sync_out and fcnt == FILT_LEN-1: sync_out <= r and fcnt <= 0.
  - r == sync_out: fcnt <= 0.
  - sync_out becomes a register with reset value RST_VAL. It changes at edge STAGES+FILT_LEN.
  - Any r excursion shorter than FILT_LEN cycles is suppressed: no sync_out change and no pulse.
- Not defined: no filter logic exists, FILT_LEN is ignored, and sync_out = r.

## Test plan
- Reset: rst_n=0 with async_in=4'hF, release → sync_out=0, no pulses, edge_cnt=0. Edge STAGES after release: sync_out=4'hF. Next cycle: rise_pulse=4'hF, any_edge=1. Then edge_cnt=4.
- Single channel, STAGES=3, no filter: async_in[1] 0→1 before edge 1 → sync_out[1]=1 after edge 3, rise_pulse[1] high for one cycle after edge 4 only, edge_cnt=1.
- Saturation: drive 0x10000 edges with edge_cnt near 0xFFFC on CH=4 toggling all bits → edge_cnt stops at 0xFFFF. Assert cnt_clr in a pulse cycle → edge_cnt=0, not 4.
- Deglitch on, FILT_LEN=3: 2-cycle high glitch on async_in[0] → sync_out[0] stays 0, no pulses. 3-cycle-stable high → sync_out[0]=1 at edge STAGES+3, one rise_pulse.
- Reset mid-operation: assert rst_n while a rise_pulse is high and fcnt is non-zero → all outputs return to reset values immediately (asynchronous), and the first post-release cycle shows no pulse.
